// File: rtl/fft_stage_ctrl.sv
// rtl/fft_stage_ctrl.sv - in-place radix-2 DIT FFT sequencer around an external butterfly
module fft_stage_ctrl #(
  parameter int NBITS  = 16,
  parameter int LOG2N  = 4,
  parameter int BF_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_r,
  input  logic [NBITS-1:0] in_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_r,
  output logic [NBITS-1:0] out_i,
  output logic             out_last,
  output logic             busy,
  output logic [NBITS-1:0] bf_ar,
  output logic [NBITS-1:0] bf_ai,
  output logic [NBITS-1:0] bf_br,
  output logic [NBITS-1:0] bf_bi,
  output logic [LOG2N-2:0] tw_addr,
  input  logic [NBITS-1:0] bf_xr,
  input  logic [NBITS-1:0] bf_xi,
  input  logic [NBITS-1:0] bf_yr,
  input  logic [NBITS-1:0] bf_yi
);
  localparam int N  = 1 << LOG2N;
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_DRAIN, S_UNLOAD} state_t;

  state_t           state, state_nx;
  logic [LOG2N-1:0] cnt, cnt_nx;   // sample index n, butterfly index k, or bin index u
  logic [LOG2N-1:0] stg, stg_nx;
  logic [DW-1:0]    dcnt, dcnt_nx;
  logic             issue, load_we, wb;

  // Sample store: not reset, contents only meaningful after a full LOAD
  logic [2*NBITS-1:0] mem [N];

  // Pending write-back addresses, one slot per butterfly latency edge
  logic [BF_LAT-1:0] dl_v;
  logic [LOG2N-1:0]  dl_a [BF_LAT];
  logic [LOG2N-1:0]  dl_b [BF_LAT];

  logic [LOG2N-1:0] h, j, idx_a, idx_b, tsh;
  logic [LOG2N-2:0] tw;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    for (int b = 0; b < LOG2N; b++) bitrev[b] = v[LOG2N-1-b];
  endfunction

  // Butterfly operand indices and twiddle address for stage stg, butterfly cnt
  always_comb begin
    h     = LOG2N'(1) << stg;
    j     = cnt & (h - 1'b1);
    idx_a = ((cnt >> stg) << (stg + 1'b1)) | j;
    idx_b = idx_a | h;
    tsh   = LOG2N'(LOG2N - 1) - stg;
    tw    = (LOG2N-1)'(j) << tsh;
  end

  // Next-state and sequencing strobes
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stg_nx   = stg;
    dcnt_nx  = dcnt;
    issue    = 1'b0;
    load_we  = 1'b0;
    case (state)
      S_LOAD: begin
        if (in_valid) begin
          load_we = 1'b1;
          cnt_nx  = cnt + 1'b1;
          if (cnt == LOG2N'(N - 1)) begin
            state_nx = S_ISSUE;
            cnt_nx   = '0;
            stg_nx   = '0;
          end
        end
      end
      S_ISSUE: begin
        issue  = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == LOG2N'(N/2 - 1)) begin
          state_nx = S_DRAIN;
          cnt_nx   = '0;
          dcnt_nx  = '0;
        end
      end
      S_DRAIN: begin
        dcnt_nx = dcnt + 1'b1;
        if (dcnt == DW'(BF_LAT - 1)) begin
          dcnt_nx = '0;
          if (stg == LOG2N'(LOG2N - 1)) begin
            state_nx = S_UNLOAD;
            cnt_nx   = '0;
          end else begin
            state_nx = S_ISSUE;
            stg_nx   = stg + 1'b1;
          end
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          cnt_nx = cnt + 1'b1;
          if (cnt == LOG2N'(N - 1)) begin
            state_nx = S_LOAD;
            cnt_nx   = '0;
          end
        end
      end
      default: state_nx = S_LOAD;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_LOAD;
      cnt   <= '0;
      stg   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      stg   <= stg_nx;
      dcnt  <= dcnt_nx;
    end
  end

  // Delay line tracking in-flight butterflies; only the valids are cleared on reset
  always_ff @(posedge clk) begin
    if (!rst_n) dl_v <= '0;
    else begin
      dl_v[0] <= issue;
      for (int i = 1; i < BF_LAT; i++) dl_v[i] <= dl_v[i-1];
    end
    dl_a[0] <= idx_a;
    dl_b[0] <= idx_b;
    for (int i = 1; i < BF_LAT; i++) begin
      dl_a[i] <= dl_a[i-1];
      dl_b[i] <= dl_b[i-1];
    end
  end

  assign wb = rst_n && dl_v[BF_LAT-1];

  // Storage writes: bit-reversed load, in-place butterfly write-back
  always_ff @(posedge clk) begin
    if (rst_n && load_we) mem[bitrev(cnt)] <= {in_r, in_i};
    if (wb) begin
      mem[dl_a[BF_LAT-1]] <= {bf_xr, bf_xi};
      mem[dl_b[BF_LAT-1]] <= {bf_yr, bf_yi};
    end
  end

  // Port outputs, forced to zero outside their active state and during reset
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_r     = '0;
    out_i     = '0;
    bf_ar     = '0;
    bf_ai     = '0;
    bf_br     = '0;
    bf_bi     = '0;
    tw_addr   = '0;
    if (rst_n) begin
      case (state)
        S_LOAD:  in_ready = 1'b1;
        S_ISSUE: begin
          busy           = 1'b1;
          {bf_ar, bf_ai} = mem[idx_a];
          {bf_br, bf_bi} = mem[idx_b];
          tw_addr        = tw;
        end
        S_DRAIN: busy = 1'b1;
        S_UNLOAD: begin
          out_valid      = 1'b1;
          {out_r, out_i} = mem[cnt];
          out_last       = (cnt == LOG2N'(N - 1));
        end
        default: ;
      endcase
    end
  end
endmodule
